// File: rtl/tt_regfile_responder.sv
// rtl/tt_regfile_responder.sv - req/ack byte-bus responder over a 16 x 8 register file
// Optional handshake watchdog with sticky err: define RESP_TIMEOUT_EN.
module tt_regfile_responder #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK_CMD,
    ST_WAIT_DATA,
    ST_ACK_DATA,
    ST_ACK_RD
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] r_req_sync;
  logic       w_req_s;
  logic [7:0] r_regs [16];
  logic [3:0] r_addr;
  logic [7:0] r_uo;
  logic       r_ack;
  logic       r_busy;
  logic       w_next_ack;
  logic       w_rd_load;
  logic       w_wr_en;
  logic       w_addr_load;
  logic       w_err_set;
  logic       w_err_clr;
  logic       w_timeout;
  logic       w_err;

  // req is asynchronous to clk; only the second stage feeds the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_sync <= 2'b00;
    end else begin
      r_req_sync <= {r_req_sync[0], uio_in[0]};
    end
  end

  assign w_req_s = r_req_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_ack   <= w_next_ack;
      r_busy  <= (w_next_state != ST_IDLE);
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_ack   = r_ack;
    w_rd_load    = 1'b0;
    w_wr_en      = 1'b0;
    w_addr_load  = 1'b0;
    w_err_set    = 1'b0;
    w_err_clr    = 1'b0;
    if (!ena) begin
      w_next_state = ST_IDLE;
      w_next_ack   = 1'b0;
    end else if (w_timeout) begin
      w_next_state = ST_IDLE;
      w_next_ack   = 1'b0;
      w_err_set    = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_s) begin
            w_err_clr  = 1'b1;
            w_next_ack = 1'b1;
            if (ui_in[7]) begin
              w_addr_load  = 1'b1;
              w_next_state = ST_ACK_CMD;
            end else begin
              w_rd_load    = 1'b1;
              w_next_state = ST_ACK_RD;
            end
          end
        end
        ST_ACK_CMD: begin
          if (!w_req_s) begin
            w_next_ack   = 1'b0;
            w_next_state = ST_WAIT_DATA;
          end
        end
        ST_WAIT_DATA: begin
          if (w_req_s) begin
            w_wr_en      = 1'b1;
            w_next_ack   = 1'b1;
            w_next_state = ST_ACK_DATA;
          end
        end
        ST_ACK_DATA, ST_ACK_RD: begin
          if (!w_req_s) begin
            w_next_ack   = 1'b0;
            w_next_state = ST_IDLE;
          end
        end
        default: begin
          w_next_state = ST_IDLE;
          w_next_ack   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= 4'h0;
      r_uo   <= 8'h00;
      for (int i = 0; i < 16; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else begin
      if (w_addr_load) begin
        r_addr <= ui_in[3:0];
      end
      if (w_rd_load) begin
        r_uo <= r_regs[ui_in[3:0]];
      end
      if (w_wr_en) begin
        r_regs[r_addr] <= ui_in;
      end
    end
  end

`ifdef RESP_TIMEOUT_EN
  localparam logic [7:0] LP_TIMEOUT = 8'(TIMEOUT_CYCLES);

  logic [7:0] r_cnt;
  logic       r_err;

  // Counter restarts on every state change so each handshake phase gets the full budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'h00;
    end else if ((r_state == ST_IDLE) || (w_next_state != r_state)) begin
      r_cnt <= 8'h00;
    end else if (r_cnt != LP_TIMEOUT) begin
      r_cnt <= r_cnt + 8'h01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else if (w_err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign w_timeout = (r_state != ST_IDLE) && (r_cnt == LP_TIMEOUT);
  assign w_err     = r_err;
`else
  logic w_unused_timeout;

  assign w_timeout        = 1'b0;
  assign w_err            = 1'b0;
  assign w_unused_timeout = &{1'b0, w_err_set, w_err_clr, 1'(TIMEOUT_CYCLES)};
`endif

  logic w_unused_pins;
  assign w_unused_pins = &{1'b0, uio_in[7:1]};

  assign uo_out  = r_uo;
  assign uio_out = {3'b000, w_err, r_busy, r_ack, 2'b00};
  assign uio_oe  = 8'h1C;

endmodule

// File: tb/tb_tt_regfile_responder.sv
// tb/tb_tt_regfile_responder.sv - randomized self-checking bench against a register-array model
// Define RESP_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES = 20).
module tb_tt_regfile_responder;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int errors;
  int checks;
  logic [7:0] model [16];

  tt_regfile_responder #(.TIMEOUT_CYCLES(20)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one req level and count falling-edge samples until ack follows it.
  task automatic phase(input logic lvl, input logic [7:0] data, output int lat);
    if (lvl) ui_in = data;
    uio_in[0] = lvl;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while ((uio_out[2] !== lvl) && (lat < 40));
  endtask

  task automatic do_read(input logic [3:0] addr, input string tag);
    int lat;
    phase(1'b1, {1'b0, 3'($urandom_range(0, 7)), addr}, lat);
    check({tag, "_ack_rise_lat"}, 8'(lat), 8'd3);
    check({tag, "_data"}, uo_out, model[addr]);
    check({tag, "_busy"}, {7'b0, uio_out[3]}, 8'h01);
    phase(1'b0, 8'h00, lat);
    check({tag, "_ack_fall_lat"}, 8'(lat), 8'd3);
    check({tag, "_idle_out"}, uio_out, 8'h00);
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [7:0] data, input string tag);
    int lat;
    phase(1'b1, {1'b1, 3'($urandom_range(0, 7)), addr}, lat);
    check({tag, "_cmd_lat"}, 8'(lat), 8'd3);
    phase(1'b0, 8'h00, lat);
    phase(1'b1, data, lat);
    check({tag, "_data_lat"}, 8'(lat), 8'd3);
    phase(1'b0, 8'h00, lat);
    check({tag, "_done"}, uio_out, 8'h00);
    model[addr] = data;
  endtask

  initial begin
    int lat;
    errors = 0;
    checks = 0;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_uo_out", uo_out, 8'h00);
    check("rst_uio_out", uio_out, 8'h00);
    check("rst_uio_oe", uio_oe, 8'h1C);
    rst_n = 1'b1;
    @(negedge clk);

    do_read(4'h5, "rd5_after_reset");
    check("oe_during_traffic", uio_oe, 8'h1C);

    do_write(4'h3, 8'hA5, "wr3");
    for (int a = 0; a < 16; a++) do_read(4'(a), "sweep_after_wr3");

    // ena drop in the middle of a read handshake
    do_write(4'hF, 8'h3C, "wr15");
    phase(1'b1, 8'h0F, lat);
    check("ena_rd_data", uo_out, 8'h3C);
    ena = 1'b0;
    @(negedge clk);
    check("ena_low_out", uio_out, 8'h00);
    check("ena_low_uo_hold", uo_out, 8'h3C);
    uio_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    ena = 1'b1;
    @(negedge clk);
    do_read(4'hF, "rd15_after_ena");

    // async reset while a write waits for its data phase
    phase(1'b1, 8'h87, lat);
    phase(1'b0, 8'h00, lat);
    check("wait_data_busy", uio_out, 8'h08);
    ui_in = 8'h99;
    uio_in[0] = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst_out", uio_out, 8'h00);
    uio_in[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    @(negedge clk);
    do_read(4'h7, "rd7_after_rst");

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) do_write(4'($urandom_range(0, 15)), 8'($urandom), "rand_wr");
      else do_read(4'($urandom_range(0, 15)), "rand_rd");
    end

    for (int a = 0; a < 16; a++) do_write(4'(a), 8'(a) ^ 8'h5A, "b2b_wr");
    for (int a = 0; a < 16; a++) do_read(4'(a), "b2b_rd");

`ifdef RESP_TIMEOUT_EN
    begin
      int cyc;
      phase(1'b1, 8'h89, lat);
      cyc = 0;
      while ((uio_out[3] !== 1'b0) && (cyc < 60)) begin
        @(negedge clk);
        cyc++;
      end
      check("to_cmd_idle_err", uio_out, 8'h10);
      // req still high: the next IDLE edge accepts a fresh command and clears err
      @(negedge clk);
      check("to_err_cleared", uio_out, 8'h0C);
      phase(1'b0, 8'h00, lat);
      cyc = 0;
      while ((uio_out[3] !== 1'b0) && (cyc < 60)) begin
        @(negedge clk);
        cyc++;
      end
      check("to_wait_data_err", uio_out, 8'h10);
      do_read(4'h9, "to_rd9_unchanged");
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tt_regfile_responder.md
# tt_regfile_responder

Design-side responder for the host-driven byte bus on the TinyTapeout pins. The host (the cocotb bench, or the board MCU in silicon) drives command and data bytes on `ui_in` with a 4-phase req/ack handshake on `uio_in`/`uio_out`. The block decodes each transaction against a 16 x 8 register file and returns read data on `uo_out`. It sits directly under `tt_um_top`, fed from the top-level pins.

## Interface
- `TIMEOUT_CYCLES`, default 255: handshake watchdog limit in clocks. Used only with `RESP_TIMEOUT_EN`. Range 1..255.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `ena` in 1: design selected. Low forces IDLE synchronously.
- `ui_in` in 8: command byte or write-data byte.
- `uio_in` in 8: bit 0 = `req` (asynchronous to `clk`). Other bits are ignored.
- `uo_out` out 8: read data. Holds its last value between reads.
- `uio_out` out 8: bit 2 = `ack`, bit 3 = `busy`, bit 4 = `err`. All other bits are 0.
- `uio_oe` out 8: constant 8'h1C.

## Operation
- `req` passes through a 2-FF synchronizer to produce `req_s`. The FSM uses only `req_s`.
- Command byte format:
  - bit 7 = `we` (1 = write).
  - bits 6:4 are ignored.
  - bits 3:0 = `addr`.
- FSM states and transitions:
  - IDLE: when `req_s` = 1, latch `ui_in` as the command.
    - Read: `uo_out <= regs[addr]`, `ack <= 1`, go to ACK_RD.
    - Write: latch `addr`, `ack <= 1`, go to ACK_CMD.
  - ACK_CMD: when `req_s` = 0, `ack <= 0`, go to WAIT_DATA.
  - WAIT_DATA: when `req_s` = 1, `regs[addr] <= ui_in`, `ack <= 1`, go to ACK_DATA.
  - ACK_DATA and ACK_RD: when `req_s` = 0, `ack <= 0`, go to IDLE.
- `busy` = (state != IDLE). It is registered.
- `ui_in` is sampled only on the cycle the FSM accepts `req_s` = 1. The host must hold `ui_in` stable from raising `req` until it sees `ack`.
- Registers are all read/write, 8 bits each, no side effects on access. Addresses always hit; there is no decode error.
- `ena` = 0: next edge goes to IDLE with `ack` = 0 and `busy` = 0. Registers and `uo_out` are retained. A pending write is dropped.
- `req_s` already high on entry to IDLE (e.g. after `ena` returns, or after a timeout): it is treated as a new command. The host must drop `req` before its next command.

## Timing
- Reset values: state = IDLE, all registers = 8'h00, `uo_out` = 8'h00, `ack` = `busy` = `err` = 0.
- Reset asserted mid-transaction aborts it immediately and asynchronously. A pending write is lost.
- `req` pin rise to `ack` rise: 3 rising edges (2 synchronizer edges + 1 FSM edge).
- `req` fall to `ack` fall: also 3 edges.
- Read data is valid on `uo_out` in the same cycle `ack` rises, and stays valid until the next read is accepted.
- A write becomes visible in `regs` on the edge where the data-phase `ack` rises. A read issued immediately afterwards returns the new value.
- Minimum full read transaction is 6 clocks; minimum write is 12 clocks.

## Configuration
- Macro: `RESP_TIMEOUT_EN`.
- Defined:
  - An 8-bit watchdog counter runs in every non-IDLE state and clears on each state change.
  - When it reaches `TIMEOUT_CYCLES`, the next edge forces IDLE with `ack` = 0 and sets `err` = 1.
  - A pending write in WAIT_DATA is discarded.
  - `err` is sticky. It is cleared only by reset or by the next accepted command in IDLE.
- Undefined: no counter is synthesized, `err` is tied to 0, and the FSM waits indefinitely in any state.

## Test plan
- After reset, read addr 4'h5 (cmd 8'h05): `ack` rises 3 edges after `req`, `uo_out` = 8'h00, and `uio_oe` = 8'h1C throughout.
- Write 8'hA5 to addr 3 (cmd 8'h83, then data 8'hA5), then read cmd 8'h03: `uo_out` = 8'hA5, and every other address still reads 8'h00.
- Write 8'h3C to addr 15, then drive `ena` = 0 mid read-handshake: `ack` and `busy` drop within 1 edge. With `ena` back to 1 and `req` cycled, read addr 15 returns 8'h3C.
- Assert `rst_n` = 0 while in WAIT_DATA of a write to addr 7: `ack` and `busy` go to 0 asynchronously, and a read of addr 7 returns 8'h00.
- With `RESP_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 20, leave `req` high in ACK_CMD: the FSM reaches IDLE with `err` = 1 after 20 cycles, and the target register is unchanged. `err` clears on the next accepted command.
- Issue back-to-back reads of addrs 0..15 after writing `value = addr ^ 8'h5A`: each `uo_out` matches, and `ack` never overlaps `req` = 0 by more than 3 edges.
